// File: rtl/shift_sched_pkg.sv
// Shared types, defaults and arithmetic helpers for the DAC shift scheduler.
// MAX_SHIFT is one DAC word short of the full shifter depth, in samples.
package shift_sched_pkg;

    localparam int unsigned NUM_STAGES_DEF    = 16;
    localparam int unsigned SHIFT_W_DEF       = 8;
    localparam int unsigned FRAME_W_DEF       = 16;
    localparam int unsigned SETTLE_CYCLES_DEF = 16;
    localparam int unsigned MAX_SHIFT         = (NUM_STAGES_DEF - 32'd1) * 32'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    function automatic int unsigned max_shift_of(input int unsigned num_stages);
        return (num_stages - 32'd1) * 32'd16;
    endfunction

    // Next shift value; wide arithmetic so the ramp can never wrap past the target.
    function automatic int unsigned next_shift(
        input int unsigned cur,
        input int unsigned tgt,
        input int unsigned step,
        input logic        ramp
    );
        int unsigned diff;
        int unsigned delta;
        int unsigned result;
        if (tgt > cur) begin
            diff = tgt - cur;
        end else begin
            diff = cur - tgt;
        end
        if (step < diff) begin
            delta = step;
        end else begin
            delta = diff;
        end
        if (!ramp) begin
            result = tgt;
        end else if (tgt > cur) begin
            result = cur + delta;
        end else begin
            result = cur - delta;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_sched_if.sv
// Host-side configuration port of the shift scheduler (valid/ready request).
interface shift_sched_if
    import shift_sched_pkg::*;
#(
    parameter int unsigned SHIFT_W = SHIFT_W_DEF
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [SHIFT_W-1:0] cfg_target;
    logic [SHIFT_W-1:0] cfg_step;
    logic               cfg_ramp;
    logic               cfg_abort;

    modport master (
        output cfg_valid, cfg_target, cfg_step, cfg_ramp, cfg_abort,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_target, cfg_step, cfg_ramp, cfg_abort,
        output cfg_ready
    );
endinterface

// File: rtl/shift_frame_timer.sv
// Frame timer: counts 0..L-1 while enabled and emits a registered tick after L-1.
// The frame length is captured while idle and at every wrap so a frame is never resized mid-way.
module shift_frame_timer
    import shift_sched_pkg::*;
#(
    parameter int unsigned FRAME_W = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [FRAME_W-1:0] frame_len,
    output logic               frame_tick
);

    logic [FRAME_W-1:0] cnt_r;
    logic [FRAME_W-1:0] len_r;
    logic [FRAME_W-1:0] len_eff_s;
    logic               wrap_s;

    // Effective length (0 behaves as 1) and end-of-frame detect.
    always_comb begin
        if (frame_len == {FRAME_W{1'b0}}) begin
            len_eff_s = FRAME_W'(1);
        end else begin
            len_eff_s = frame_len;
        end
        if (cnt_r >= (len_r - FRAME_W'(1))) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Frame counter, length capture and tick register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r      <= {FRAME_W{1'b0}};
            len_r      <= FRAME_W'(1);
            frame_tick <= 1'b0;
        end else if (!enable) begin
            cnt_r      <= {FRAME_W{1'b0}};
            len_r      <= len_eff_s;
            frame_tick <= 1'b0;
        end else if (wrap_s) begin
            cnt_r      <= {FRAME_W{1'b0}};
            len_r      <= len_eff_s;
            frame_tick <= 1'b1;
        end else begin
            cnt_r      <= cnt_r + FRAME_W'(1);
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_sched.sv
// DAC shift scheduler: applies clamped target shifts as jumps or bounded ramps,
// only on frame boundaries, followed by a fixed settle window.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = NUM_STAGES_DEF,
    parameter int unsigned SHIFT_W       = SHIFT_W_DEF,
    parameter int unsigned FRAME_W       = FRAME_W_DEF,
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [FRAME_W-1:0] frame_len,
    shift_sched_if.slave       cfg,
    output logic [SHIFT_W-1:0] shift_amt,
    output logic               shift_update,
    output logic               settling,
    output logic               frame_tick,
    output logic               clamped
);

    localparam int unsigned        MAX_SHIFT_L = max_shift_of(NUM_STAGES);
    localparam logic [SHIFT_W-1:0] MAX_SHIFT_W = SHIFT_W'(MAX_SHIFT_L);
    localparam int                 CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_r;
    logic [SHIFT_W-1:0] target_r;
    logic [SHIFT_W-1:0] step_r;
    logic               ramp_r;
    logic               abort_r;
    logic [CNT_W-1:0]   settle_cnt_r;

    logic [SHIFT_W-1:0] tgt_clamped_s;
    logic               over_s;
    logic [SHIFT_W-1:0] step_eff_s;
    logic [SHIFT_W-1:0] next_amt_s;

    shift_frame_timer #(
        .FRAME_W (FRAME_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frame_len  (frame_len),
        .frame_tick (frame_tick)
    );

    // Request conditioning and next shift value.
    always_comb begin
        tgt_clamped_s = cfg.cfg_target;
        over_s        = 1'b0;
        if (cfg.cfg_target > MAX_SHIFT_W) begin
            tgt_clamped_s = MAX_SHIFT_W;
            over_s        = 1'b1;
        end else begin
            tgt_clamped_s = cfg.cfg_target;
            over_s        = 1'b0;
        end
        if (cfg.cfg_step == {SHIFT_W{1'b0}}) begin
            step_eff_s = SHIFT_W'(1);
        end else begin
            step_eff_s = cfg.cfg_step;
        end
        next_amt_s = SHIFT_W'(next_shift(32'(shift_amt), 32'(target_r), 32'(step_r), ramp_r));
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            shift_amt     <= {SHIFT_W{1'b0}};
            shift_update  <= 1'b0;
            settling      <= 1'b0;
            clamped       <= 1'b0;
            target_r      <= {SHIFT_W{1'b0}};
            step_r        <= SHIFT_W'(1);
            ramp_r        <= 1'b0;
            abort_r       <= 1'b0;
            settle_cnt_r  <= {CNT_W{1'b0}};
            cfg.cfg_ready <= 1'b1;
        end else begin
            shift_update <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cfg.cfg_valid) begin
                        target_r      <= tgt_clamped_s;
                        step_r        <= step_eff_s;
                        ramp_r        <= cfg.cfg_ramp;
                        abort_r       <= 1'b0;
                        clamped       <= clamped | over_s;
                        state_r       <= WAIT;
                        cfg.cfg_ready <= 1'b0;
                    end else begin
                        state_r       <= IDLE;
                        cfg.cfg_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (frame_tick) begin
                        // A simultaneous abort loses to the tick but still ends the request after settling.
                        abort_r <= cfg.cfg_abort;
                        if (target_r == shift_amt) begin
                            state_r       <= IDLE;
                            cfg.cfg_ready <= 1'b1;
                        end else begin
                            shift_amt    <= next_amt_s;
                            shift_update <= 1'b1;
                            settling     <= 1'b1;
                            settle_cnt_r <= SETTLE_LOAD;
                            state_r      <= SETTLE;
                        end
                    end else if (cfg.cfg_abort) begin
                        state_r       <= IDLE;
                        cfg.cfg_ready <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r == {CNT_W{1'b0}}) begin
                        settling <= 1'b0;
                        if ((shift_amt == target_r) || abort_r || cfg.cfg_abort) begin
                            state_r       <= IDLE;
                            cfg.cfg_ready <= 1'b1;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else begin
                        settle_cnt_r <= settle_cnt_r - CNT_W'(1);
                        abort_r      <= abort_r | cfg.cfg_abort;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    settling      <= 1'b0;
                    cfg.cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: expected shift updates are queued by the stimulus
// and matched by a monitor that also measures every settle window.
module tb_shift_sched;

    typedef struct {
        int amt;
        int cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] frame_len;
    logic [7:0]  shift_amt;
    logic        shift_update;
    logic        settling;
    logic        frame_tick;
    logic        clamped;

    int   cyc;
    int   checks;
    int   failures;
    int   run;
    exp_t q[$];

    shift_sched_if #(.SHIFT_W(8)) cfg_bus ();

    shift_sched #(
        .NUM_STAGES    (16),
        .SHIFT_W       (8),
        .FRAME_W       (16),
        .SETTLE_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .frame_len    (frame_len),
        .cfg          (cfg_bus.slave),
        .shift_amt    (shift_amt),
        .shift_update (shift_update),
        .settling     (settling),
        .frame_tick   (frame_tick),
        .clamped      (clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int amt, input int c);
        exp_t e;
        e.amt = amt;
        e.cyc = c;
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset(input logic [15:0] len);
        rst                 = 1'b0;
        enable              = 1'b0;
        frame_len           = len;
        cfg_bus.cfg_valid   = 1'b0;
        cfg_bus.cfg_abort   = 1'b0;
        cfg_bus.cfg_ramp    = 1'b0;
        cfg_bus.cfg_target  = 8'd0;
        cfg_bus.cfg_step    = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic start(output int e);
        enable = 1'b1;
        e      = cyc;
    endtask

    task automatic wait_tick(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        c = frame_tick ? cyc : -1;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!cfg_bus.cfg_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("ready_within_budget", int'(cfg_bus.cfg_ready), 1);
    endtask

    task automatic send(input int tgt, input int step, input logic ramp, output int acc);
        wait_ready(300);
        cfg_bus.cfg_target = 8'(tgt);
        cfg_bus.cfg_step   = 8'(step);
        cfg_bus.cfg_ramp   = ramp;
        cfg_bus.cfg_valid  = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        cfg_bus.cfg_valid  = 1'b0;
    endtask

    initial begin
        int e;
        int a;
        int t;
        int r;
        exp_t x;
        checks   = 0;
        failures = 0;
        run      = 0;
        cyc      = 0;
        rst      = 1'b0;
        enable   = 1'b0;
        frame_len = 16'd10;
        cfg_bus.cfg_valid  = 1'b0;
        cfg_bus.cfg_abort  = 1'b0;
        cfg_bus.cfg_ramp   = 1'b0;
        cfg_bus.cfg_target = 8'd0;
        cfg_bus.cfg_step   = 8'd0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    run = 0;
                end else begin
                    if (settling) begin
                        run++;
                    end else if (run > 0) begin
                        chk("settle_len", run, 16);
                        run = 0;
                    end
                    if (shift_update) begin
                        if (q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_update: shift_amt=%0d with nothing queued (cycle %0d)", shift_amt, cyc);
                        end else begin
                            x = q.pop_front();
                            chk("shift_amt", int'(shift_amt), x.amt);
                            if (x.cyc >= 0) chk("update_cycle", cyc, x.cyc);
                            chk("shift_in_window", int'(shift_amt <= 8'd240), 1);
                        end
                    end
                end
            end
        join_none

        // Reset state and frame timer at L=10
        do_reset(16'd10);
        chk("rst_shift_amt", int'(shift_amt), 0);
        chk("rst_update", int'(shift_update), 0);
        chk("rst_settling", int'(settling), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_clamped", int'(clamped), 0);
        chk("rst_ready", int'(cfg_bus.cfg_ready), 1);
        start(e);
        wait_tick(t); chk("tick1", t, e + 10);
        wait_tick(t); chk("tick2", t, e + 20);
        wait_tick(t); chk("tick3", t, e + 30);
        chk("idle_shift_amt", int'(shift_amt), 0);
        chk("idle_ready", int'(cfg_bus.cfg_ready), 1);

        // Jump to 37 accepted at cycle 3
        do_reset(16'd10);
        start(e);
        wait_until(e + 2);
        send(37, 0, 1'b0, a);
        chk("jump_accept", a, e + 3);
        push(37, e + 11);
        wait_until(e + 26);
        chk("jump_ready_in_settle", int'(cfg_bus.cfg_ready), 0);
        chk("jump_settling_last", int'(settling), 1);
        wait_until(e + 27);
        chk("jump_ready_after", int'(cfg_bus.cfg_ready), 1);
        chk("jump_settling_done", int'(settling), 0);
        chk("jump_final", int'(shift_amt), 37);

        // Ramp 0 -> 10 step 4, then 10 -> 2 step 5
        do_reset(16'd20);
        start(e);
        send(10, 4, 1'b1, a);
        push(4, e + 21);
        push(8, e + 41);
        push(10, e + 61);
        wait_ready(200);
        chk("ramp_idle_cycle", cyc, e + 77);
        send(2, 5, 1'b1, a);
        push(5, -1);
        push(2, -1);
        wait_ready(200);
        chk("ramp_down_final", int'(shift_amt), 2);

        // Clamp: 240 is legal, 255 clamps, flag stays sticky
        do_reset(16'd5);
        start(e);
        send(240, 0, 1'b0, a);
        chk("clamp_240_flag", int'(clamped), 0);
        push(240, -1);
        wait_ready(100);
        send(100, 0, 1'b0, a);
        push(100, -1);
        wait_ready(100);
        send(255, 0, 1'b0, a);
        chk("clamp_255_flag", int'(clamped), 1);
        push(240, -1);
        wait_ready(100);
        chk("clamp_final", int'(shift_amt), 240);
        send(50, 0, 1'b0, a);
        push(50, -1);
        wait_ready(100);
        chk("clamp_sticky", int'(clamped), 1);
        chk("clamp_after", int'(shift_amt), 50);

        // Abort in WAIT before any tick
        do_reset(16'd20);
        start(e);
        send(50, 0, 1'b0, a);
        wait_until(e + 5);
        cfg_bus.cfg_abort = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_abort = 1'b0;
        chk("abort_wait_ready", int'(cfg_bus.cfg_ready), 1);
        wait_until(e + 25);
        chk("abort_wait_shift", int'(shift_amt), 0);

        // Abort during SETTLE of ramp 0 -> 20 step 4
        do_reset(16'd20);
        start(e);
        send(20, 4, 1'b1, a);
        push(4, e + 21);
        wait_until(e + 25);
        cfg_bus.cfg_abort = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_abort = 1'b0;
        wait_until(e + 36);
        chk("abort_settle_busy", int'(cfg_bus.cfg_ready), 0);
        wait_until(e + 37);
        chk("abort_settle_ready", int'(cfg_bus.cfg_ready), 1);
        wait_until(e + 70);
        chk("abort_settle_shift", int'(shift_amt), 4);

        // frame_len=0 ticks every cycle; equal target gives no update
        do_reset(16'd0);
        start(e);
        wait_tick(t); chk("len0_tick1", t, e + 1);
        wait_tick(t); chk("len0_tick2", t, e + 2);
        wait_tick(t); chk("len0_tick3", t, e + 3);
        send(7, 0, 1'b0, a);
        push(7, -1);
        wait_ready(40);
        send(7, 3, 1'b1, a);
        wait_ready(8);
        chk("equal_target_shift", int'(shift_amt), 7);

        // Reset mid-ramp
        do_reset(16'd10);
        start(e);
        send(100, 10, 1'b1, a);
        push(10, e + 11);
        push(20, e + 31);
        wait_until(e + 35);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_shift", int'(shift_amt), 0);
        chk("midrst_settling", int'(settling), 0);
        chk("midrst_ready", int'(cfg_bus.cfg_ready), 1);
        @(negedge clk);
        rst = 1'b1;

        // enable=0 while WAIT stalls the request
        do_reset(16'd10);
        start(e);
        send(30, 0, 1'b0, a);
        wait_until(e + 4);
        enable = 1'b0;
        wait_until(e + 40);
        chk("stall_shift", int'(shift_amt), 0);
        chk("stall_ready", int'(cfg_bus.cfg_ready), 0);
        enable = 1'b1;
        r = cyc;
        push(30, r + 11);
        wait_ready(60);
        chk("stall_final", int'(shift_amt), 30);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
